// File: rtl/apb_master_arb8_if.sv
// apb_master_arb8_if: APB bus bundle between the arbitrating master and its slaves
interface apb_master_arb8_if #(
  parameter int PADDR_WIDTH8  = 32,
  parameter int PWDATA_WIDTH8 = 32,
  parameter int PRDATA_WIDTH8 = 32
);
  logic [PADDR_WIDTH8-1:0]  paddr8;
  logic                     prwd8;
  logic [PWDATA_WIDTH8-1:0] pwdata8;
  logic                     penable8;
  logic [15:0]              psel8;
  logic [PRDATA_WIDTH8-1:0] prdata8;
  logic                     pready8;
  logic                     pslverr8;
  modport master (output paddr8, prwd8, pwdata8, penable8, psel8, input prdata8, pready8, pslverr8);
  modport slave  (input paddr8, prwd8, pwdata8, penable8, psel8, output prdata8, pready8, pslverr8);
endinterface

// File: rtl/apb_master_arb8.sv
// apb_master_arb8: round-robin arbiter sharing one APB bus between NUM_REQ requesters
module apb_master_arb8 #(
  parameter int NUM_REQ       = 4,
  parameter int PADDR_WIDTH8  = 32,
  parameter int PWDATA_WIDTH8 = 32,
  parameter int PRDATA_WIDTH8 = 32,
  parameter int SEL_SHIFT     = 12,
  parameter int TIMEOUT       = 255
) (
  input  logic                             pclock8,
  input  logic                             preset8,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*PADDR_WIDTH8-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*PWDATA_WIDTH8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [PRDATA_WIDTH8-1:0]         rsp_rdata,
  output logic                             rsp_err,
  apb_master_arb8_if.master                apb
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t     state;
  logic [2:0] ptr, gnt, own;
  logic [9:0] cnt;
  logic       any;
  logic [3:0] sel;
  logic       done;
  // first pending requester at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    any = 1'b0;
    gnt = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        any = 1'b1;
        gnt = 3'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign sel       = req_addr[int'(gnt)*PADDR_WIDTH8 + SEL_SHIFT +: 4];
  assign req_ready = (preset8 && state == IDLE && any) ? NUM_REQ'(1) << gnt : '0;
  assign done      = apb.pready8 || cnt == 10'(TIMEOUT);
  // transfer sequencer: grant, SETUP, ACCESS with watchdog, registered response
  always_ff @(posedge pclock8 or negedge preset8) begin
    if (!preset8) begin
      state        <= IDLE;
      ptr          <= '0;
      own          <= '0;
      cnt          <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      apb.paddr8   <= '0;
      apb.prwd8    <= 1'b0;
      apb.pwdata8  <= '0;
      apb.penable8 <= 1'b0;
      apb.psel8    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE:
          if (any) begin
            own         <= gnt;
            apb.paddr8  <= req_addr[int'(gnt)*PADDR_WIDTH8 +: PADDR_WIDTH8];
            apb.prwd8   <= req_write[gnt];
            apb.pwdata8 <= req_wdata[int'(gnt)*PWDATA_WIDTH8 +: PWDATA_WIDTH8];
            apb.psel8   <= 16'(1) << sel;
            state       <= SETUP;
          end
        SETUP: begin
          apb.penable8 <= 1'b1;
          cnt          <= 10'd1;
          state        <= ACCESS;
        end
        ACCESS:
          if (done) begin
            rsp_valid    <= NUM_REQ'(1) << own;
            rsp_rdata    <= (apb.pready8 && !apb.prwd8) ? apb.prdata8 : '0;
            rsp_err      <= apb.pready8 ? apb.pslverr8 : 1'b1;
            apb.psel8    <= '0;
            apb.penable8 <= 1'b0;
            ptr          <= own == 3'(NUM_REQ - 1) ? 3'd0 : own + 3'd1;
            state        <= IDLE;
          end else
            cnt <= cnt + 10'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
